// File: rtl/video_in_pkg.sv
// Shared constants and types for the video_in FIFO-to-Wishbone burst writer.
package video_in_pkg;

  localparam int unsigned VIDEO_IN_DATA_SIZE   = 32;
  localparam int unsigned VIDEO_IN_ADDR_SIZE   = 32;
  localparam int unsigned VIDEO_IN_BURST_LEN   = 16;
  localparam int unsigned VIDEO_IN_FRAME_WORDS = 76800;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [3:0] SEL_ALL     = 4'hF;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_PACK = 2'd1,
    BURST     = 2'd2,
    GAP       = 2'd3
  } burst_state_t;

endpackage

// File: rtl/video_in_addr_gen.sv
// Frame write-address, in-frame word counter and in-burst beat counter.
module video_in_addr_gen
  import video_in_pkg::*;
#(
  parameter int unsigned ADDR_SIZE   = VIDEO_IN_ADDR_SIZE,
  parameter int unsigned BURST_LEN   = VIDEO_IN_BURST_LEN,
  parameter int unsigned FRAME_WORDS = VIDEO_IN_FRAME_WORDS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic                 beat_clr_i,
  input  logic [ADDR_SIZE-1:0] base_i,
  output logic [ADDR_SIZE-1:0] adr_o,
  output logic                 last_beat_o,
  output logic                 last_frame_word_o
);

  localparam int unsigned BEAT_W = $clog2(BURST_LEN);
  localparam int unsigned WORD_W = $clog2(FRAME_WORDS + 1);

  logic [ADDR_SIZE-1:0] adr_q, adr_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic [WORD_W-1:0]    word_q, word_d;

  // Load restarts a frame at the base; each accepted beat advances one word.
  always_comb begin
    adr_d  = adr_q;
    word_d = word_q;
    beat_d = beat_q;
    if (load_i) begin
      adr_d  = base_i;
      word_d = '0;
    end else if (step_i) begin
      adr_d  = adr_q + ADDR_SIZE'(4);
      word_d = word_q + WORD_W'(1);
    end
    if (beat_clr_i) begin
      beat_d = '0;
    end else if (step_i) begin
      beat_d = beat_q + BEAT_W'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adr_q  <= '0;
      word_q <= '0;
      beat_q <= '0;
    end else begin
      adr_q  <= adr_d;
      word_q <= word_d;
      beat_q <= beat_d;
    end
  end

  assign adr_o             = adr_q;
  assign last_beat_o       = (beat_q == BEAT_W'(BURST_LEN - 1));
  assign last_frame_word_o = (word_q == WORD_W'(FRAME_WORDS));

endmodule

// File: rtl/video_in_burst_ctrl.sv
// Drains the video_in pixel FIFO into frame memory with Wishbone incrementing bursts.
module video_in_burst_ctrl
  import video_in_pkg::*;
#(
  parameter int unsigned DATA_SIZE   = VIDEO_IN_DATA_SIZE,
  parameter int unsigned ADDR_SIZE   = VIDEO_IN_ADDR_SIZE,
  parameter int unsigned BURST_LEN   = VIDEO_IN_BURST_LEN,
  parameter int unsigned FRAME_WORDS = VIDEO_IN_FRAME_WORDS
) (
  input  logic                 clk,
  input  logic                 nRST,
  input  logic                 enable,
  input  logic [ADDR_SIZE-1:0] frame_base,
  input  logic                 fifo_pack_avail,
  input  logic [DATA_SIZE-1:0] fifo_data,
  output logic                 fifo_r_ack,
  output logic                 wb_cyc_o,
  output logic                 wb_stb_o,
  output logic                 wb_we_o,
  output logic [ADDR_SIZE-1:0] wb_adr_o,
  output logic [DATA_SIZE-1:0] wb_dat_o,
  output logic [3:0]           wb_sel_o,
  output logic [2:0]           wb_cti_o,
  output logic [1:0]           wb_bte_o,
  input  logic                 wb_ack_i,
  output logic                 frame_done,
  output logic                 busy
);

  burst_state_t state_q, state_d;

  logic ag_load;
  logic ag_step;
  logic ag_beat_clr;
  logic last_beat;
  logic last_frame_word;

  video_in_addr_gen #(
    .ADDR_SIZE   (ADDR_SIZE),
    .BURST_LEN   (BURST_LEN),
    .FRAME_WORDS (FRAME_WORDS)
  ) u_addr_gen (
    .clk               (clk),
    .rst_n             (nRST),
    .load_i            (ag_load),
    .step_i            (ag_step),
    .beat_clr_i        (ag_beat_clr),
    .base_i            (frame_base),
    .adr_o             (wb_adr_o),
    .last_beat_o       (last_beat),
    .last_frame_word_o (last_frame_word)
  );

  // State register; reset abandons any burst in flight.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: bursts always run to completion, enable is only seen between bursts.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (enable) state_d = WAIT_PACK;
      WAIT_PACK: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (fifo_pack_avail) begin
          state_d = BURST;
        end
      end
      BURST:     if (wb_ack_i && last_beat) state_d = GAP;
      GAP:       state_d = enable ? WAIT_PACK : IDLE;
    endcase
  end

  // Outputs decoded from the registered state; pops follow the slave ack directly.
  always_comb begin
    wb_cyc_o    = 1'b0;
    wb_stb_o    = 1'b0;
    wb_we_o     = 1'b0;
    wb_cti_o    = CTI_CLASSIC;
    fifo_r_ack  = 1'b0;
    frame_done  = 1'b0;
    busy        = 1'b0;
    ag_load     = 1'b0;
    ag_step     = 1'b0;
    ag_beat_clr = 1'b0;
    case (state_q)
      IDLE: begin
        ag_load = enable;
      end
      WAIT_PACK: begin
        busy        = 1'b1;
        ag_beat_clr = enable && fifo_pack_avail;
      end
      BURST: begin
        busy       = 1'b1;
        wb_cyc_o   = 1'b1;
        wb_stb_o   = 1'b1;
        wb_we_o    = 1'b1;
        wb_cti_o   = last_beat ? CTI_EOB : CTI_INCR;
        fifo_r_ack = wb_ack_i;
        ag_step    = wb_ack_i;
      end
      GAP: begin
        busy       = 1'b1;
        frame_done = last_frame_word;
        ag_load    = last_frame_word;
      end
    endcase
  end

  assign wb_dat_o = fifo_data;
  assign wb_sel_o = SEL_ALL;
  assign wb_bte_o = BTE_LINEAR;

endmodule

// File: tb/tb_video_in_burst_ctrl.sv
// Bench for video_in_burst_ctrl: FIFO + random-ack slave environment, scoreboard monitor.
module tb_video_in_burst_ctrl;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 32;
  localparam int unsigned BL  = 16;
  localparam int unsigned FW  = 32;
  localparam int          MEM = 1024;

  logic          clk;
  logic          nRST;
  logic          enable;
  logic [AW-1:0] frame_base;
  logic          fifo_pack_avail;
  logic [DW-1:0] fifo_data;
  logic          fifo_r_ack;
  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic          wb_we_o;
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o;
  logic [3:0]    wb_sel_o;
  logic [2:0]    wb_cti_o;
  logic [1:0]    wb_bte_o;
  logic          wb_ack_i;
  logic          frame_done;
  logic          busy;

  video_in_burst_ctrl #(
    .DATA_SIZE   (DW),
    .ADDR_SIZE   (AW),
    .BURST_LEN   (BL),
    .FRAME_WORDS (FW)
  ) dut (
    .clk             (clk),
    .nRST            (nRST),
    .enable          (enable),
    .frame_base      (frame_base),
    .fifo_pack_avail (fifo_pack_avail),
    .fifo_data       (fifo_data),
    .fifo_r_ack      (fifo_r_ack),
    .wb_cyc_o        (wb_cyc_o),
    .wb_stb_o        (wb_stb_o),
    .wb_we_o         (wb_we_o),
    .wb_adr_o        (wb_adr_o),
    .wb_dat_o        (wb_dat_o),
    .wb_sel_o        (wb_sel_o),
    .wb_cti_o        (wb_cti_o),
    .wb_bte_o        (wb_bte_o),
    .wb_ack_i        (wb_ack_i),
    .frame_done      (frame_done),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Words written by stimulus; read independently by the FIFO model and the scoreboard.
  logic [DW-1:0] word_mem [MEM];
  int unsigned   off_mem  [MEM];
  int            wr_idx = 0;
  int            push_rd = 0;
  int            exp_rd  = 0;

  int unsigned   push_off = 0;
  logic [AW-1:0] sb_frame_base = 32'h1000;
  logic          gate = 1'b1;
  int            ack_pct = 100;
  int            beats_seen = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // FIFO and Wishbone slave, updated just after each rising edge.
  logic [DW-1:0] fifo_q[$];
  logic          xfer = 1'b0;
  always @(posedge clk) begin
    #1;
    if (!nRST) begin
      fifo_q.delete();
      push_rd = wr_idx;
      xfer    = 1'b0;
    end else begin
      if (xfer && fifo_q.size() != 0) void'(fifo_q.pop_front());
      while (push_rd != wr_idx) begin
        fifo_q.push_back(word_mem[push_rd % MEM]);
        push_rd++;
      end
    end
    fifo_data       = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    fifo_pack_avail = gate && (fifo_q.size() >= BL);
    wb_ack_i        = wb_cyc_o && wb_stb_o && (int'($urandom_range(99, 0)) < ack_pct);
    xfer            = wb_ack_i && wb_cyc_o;
  end

  // Scoreboard monitor: address = frame base + 4*offset, cti marks word BL-1 of each burst.
  logic          fd_pend = 1'b0;
  logic          gap_pend = 1'b0;
  logic          prev_stall = 1'b0;
  logic [AW-1:0] prev_adr;
  logic [DW-1:0] prev_dat;
  logic [2:0]    prev_cti;
  logic [AW-1:0] cur_base = '0;
  always @(negedge clk) begin
    if (!nRST) begin
      exp_rd     = wr_idx;
      fd_pend    = 1'b0;
      gap_pend   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      check("frame_done", 64'(frame_done), 64'(fd_pend));
      fd_pend = 1'b0;
      if (gap_pend) check("gap_cyc", 64'(wb_cyc_o), 64'(0));
      gap_pend = 1'b0;
      if (wb_cyc_o) begin
        check("stb", 64'(wb_stb_o), 64'(1));
        check("we", 64'(wb_we_o), 64'(1));
        check("sel_bte", 64'({wb_sel_o, wb_bte_o}), 64'(6'b111100));
        if (prev_stall) begin
          check("stall_adr", 64'(wb_adr_o), 64'(prev_adr));
          check("stall_dat", 64'(wb_dat_o), 64'(prev_dat));
          check("stall_cti", 64'(wb_cti_o), 64'(prev_cti));
        end
        if (wb_ack_i) begin
          if (exp_rd == wr_idx) begin
            n_checks++;
            n_fail++;
            $display("FAIL extra_beat: beat at adr 0x%0h, expected none outstanding", wb_adr_o);
          end else begin
            int unsigned off;
            off = off_mem[exp_rd % MEM];
            if (off == 0) cur_base = sb_frame_base;
            check("beat_adr", 64'(wb_adr_o), 64'(cur_base + AW'(4 * off)));
            check("beat_dat", 64'(wb_dat_o), 64'(word_mem[exp_rd % MEM]));
            check("beat_cti", 64'(wb_cti_o), ((off % BL) == BL - 1) ? 64'(3'b111) : 64'(3'b010));
            check("beat_r_ack", 64'(fifo_r_ack), 64'(1));
            fd_pend  = (off == FW - 1);
            gap_pend = ((off % BL) == BL - 1);
            exp_rd++;
            beats_seen++;
          end
          prev_stall = 1'b0;
        end else begin
          check("stall_r_ack", 64'(fifo_r_ack), 64'(0));
          prev_stall = 1'b1;
          prev_adr   = wb_adr_o;
          prev_dat   = wb_dat_o;
          prev_cti   = wb_cti_o;
        end
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_burst();
    for (int i = 0; i < int'(BL); i++) begin
      word_mem[wr_idx % MEM] = $urandom;
      off_mem[wr_idx % MEM]  = push_off;
      push_off = (push_off + 1) % FW;
      wr_idx++;
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_rd != wr_idx || wb_cyc_o) && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout_%s: %0d beats outstanding, expected 0", tag, wr_idx - exp_rd);
    end
    repeat (2) tick();
  endtask

  task automatic wait_beats(input int target, input string tag);
    int n = 0;
    while (beats_seen < target && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) begin
      n_checks++;
      n_fail++;
      $display("FAIL beat_timeout_%s: saw %0d beats, expected %0d", tag, beats_seen, target);
    end
  endtask

  initial begin
    int b0;
    nRST       = 1'b0;
    enable     = 1'b0;
    frame_base = 32'h1000;
    wb_ack_i   = 1'b0;
    fifo_data  = '0;
    fifo_pack_avail = 1'b0;
    repeat (3) tick();
    check("rst_cyc", 64'(wb_cyc_o), 64'(0));
    check("rst_stb", 64'(wb_stb_o), 64'(0));
    check("rst_we", 64'(wb_we_o), 64'(0));
    check("rst_r_ack", 64'(fifo_r_ack), 64'(0));
    check("rst_frame_done", 64'(frame_done), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_cti", 64'(wb_cti_o), 64'(0));
    check("rst_adr", 64'(wb_adr_o), 64'(0));
    nRST = 1'b1;
    tick();

    // Full-speed first burst, then randomly stalled bursts across three frames.
    enable = 1'b1;
    sb_frame_base = 32'h1000;
    for (int b = 0; b < 6; b++) begin
      if (b == 1) ack_pct = 70;
      if (b == 3) begin
        frame_base    = 32'h0002_0000;
        sb_frame_base = 32'h0002_0000;
      end
      push_burst();
      drain("frames");
    end

    // Enable drops mid-burst: burst completes, then idle with no further cycles.
    b0 = beats_seen;
    push_burst();
    wait_beats(b0 + 5, "enable_drop");
    enable = 1'b0;
    drain("enable_drop");
    check("idle_busy", 64'(busy), 64'(0));
    push_off      = 0;
    sb_frame_base = frame_base;
    push_burst();
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_no_cyc", 64'(wb_cyc_o), 64'(0));
      check("idle_no_busy", 64'(busy), 64'(0));
    end

    // Pack not available while waiting: busy without bus cycles.
    gate   = 1'b0;
    enable = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 50; i++) begin
      tick();
      check("wait_no_cyc", 64'(wb_cyc_o), 64'(0));
      check("wait_busy", 64'(busy), 64'(1));
    end
    gate = 1'b1;
    tick();
    check("avail_seen_cyc", 64'(wb_cyc_o), 64'(0));
    tick();
    check("avail_next_cyc", 64'(wb_cyc_o), 64'(1));
    drain("pack_wait");

    // Reset during beat 7 drops the bus at once; restart is at the frame base.
    b0 = beats_seen;
    push_burst();
    wait_beats(b0 + 7, "reset_mid");
    #1;
    nRST = 1'b0;
    #1;
    check("async_rst_cyc", 64'(wb_cyc_o), 64'(0));
    check("async_rst_stb", 64'(wb_stb_o), 64'(0));
    check("async_rst_r_ack", 64'(fifo_r_ack), 64'(0));
    check("async_rst_busy", 64'(busy), 64'(0));
    repeat (3) tick();
    frame_base    = 32'h0000_3000;
    sb_frame_base = 32'h0000_3000;
    push_off      = 0;
    nRST          = 1'b1;
    push_burst();
    drain("after_reset");

    // Base change mid-frame applies from the next frame; heavy stalling.
    ack_pct       = 50;
    frame_base    = 32'h0000_4000;
    sb_frame_base = 32'h0000_4000;
    for (int b = 0; b < 4; b++) begin
      push_burst();
      drain("tail");
    end

    check("all_beats_seen", 64'(exp_rd), 64'(wr_idx));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
